// File: rtl/instruction_fetch.sv
// Fetch stage: PC, credit-limited request issue, in-order response pairing and prefetch FIFO to decode.
// Optional FETCH_PERF_CNT_EN adds fetch_stall_cnt (cycles decode is starved by fetch).
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_stall_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    logic [31:0]   pc;
    fetch_entry_t  fifo_mem [FIFO_DEPTH];
    logic [31:0]   tag_mem  [FIFO_DEPTH];
    logic [PW-1:0] fifo_rd, fifo_wr, tag_rd, tag_wr;
    logic [CW-1:0] fifo_count, inflight, drop, inflight_nxt;
    logic [CW:0]   occupancy;
    logic          req_fire, rsp_keep, rsp_drop, pop;

    // Credit covers buffered words plus every outstanding request, dropped ones included.
    assign occupancy      = {1'b0, fifo_count} + {1'b0, inflight};
    assign imem_req_valid = !rst && !redirect_valid && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_drop       = imem_rsp_valid && (drop != '0);
    assign rsp_keep       = imem_rsp_valid && (drop == '0) && !redirect_valid;

    assign instr_valid = !rst && (fifo_count != '0);
    assign instr       = fifo_mem[fifo_rd].instr;
    assign instr_pc    = fifo_mem[fifo_rd].pc;
    assign pop         = instr_valid && instr_ready && !redirect_valid;

    always_comb begin
        inflight_nxt = inflight;
        if (req_fire && !imem_rsp_valid)
            inflight_nxt = inflight + CW'(1);
        else if (!req_fire && imem_rsp_valid)
            inflight_nxt = inflight - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            fifo_rd    <= '0;
            fifo_wr    <= '0;
            fifo_count <= '0;
            tag_rd     <= '0;
            tag_wr     <= '0;
            inflight   <= '0;
            drop       <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (redirect_valid) begin
                // Everything still outstanding after this edge belongs to the old path.
                pc         <= {redirect_pc[31:2], 2'b00};
                fifo_rd    <= '0;
                fifo_wr    <= '0;
                fifo_count <= '0;
                tag_rd     <= '0;
                tag_wr     <= '0;
                drop       <= inflight_nxt;
            end else begin
                if (req_fire) begin
                    pc     <= pc + 32'd4;
                    tag_wr <= tag_wr + PW'(1);
                end
                if (rsp_drop)
                    drop <= drop - CW'(1);
                if (rsp_keep) begin
                    fifo_wr <= fifo_wr + PW'(1);
                    tag_rd  <= tag_rd + PW'(1);
                end
                if (pop)
                    fifo_rd <= fifo_rd + PW'(1);
                fifo_count <= fifo_count + CW'(rsp_keep) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && req_fire)
            tag_mem[tag_wr] <= pc;
        if (!rst && rsp_keep)
            fifo_mem[fifo_wr] <= '{instr: imem_rsp_data, pc: tag_mem[tag_rd]};
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            fetch_stall_cnt <= '0;
        else if (!instr_valid && !redirect_valid)
            fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
    end
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(rsp_keep && !pop && fifo_count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: bench memory model, credit/PC model and expected-word queue.
module tb_instruction_fetch;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid, instr_ready = 1'b1;
    logic [31:0] instr, instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_stall_cnt;
`endif

    instruction_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_stall_cnt(fetch_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [31:0] addr; bit stale; } mreq_t;
    typedef struct { logic [31:0] word; logic [31:0] pc; } exp_t;

    mreq_t       mq[$];
    exp_t        sb[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] mpc = '0;
    int          cyc = 0, lat = 1, since = 0, first_valid = -1;
    int          n_chk = 0, n_pass = 0;
    logic        s_req_valid, s_instr_valid;
    logic [31:0] s_req_addr, s_stall;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock: present due response, sample at negedge, check and advance the model.
    task automatic tick();
        mreq_t m;
        exp_t  e;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end
        @(negedge clk);
        s_req_valid   = imem_req_valid;
        s_req_addr    = imem_req_addr;
        s_instr_valid = instr_valid;
        s_stall       = '0;
`ifdef FETCH_PERF_CNT_EN
        s_stall = fetch_stall_cnt;
`endif
        if (rst) begin
            chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
            chk("rst_instr_valid", 32'(instr_valid), 32'd0);
            mq.delete(); sb.delete(); acc_log.delete(); pop_log.delete();
            mpc = 32'h0; since = 0; first_valid = -1;
        end else begin
            chk("req_valid", 32'(imem_req_valid),
                32'(!redirect_valid && (sb.size() + mq.size() < DEPTH)));
            if (imem_req_valid) chk("req_addr", imem_req_addr, mpc);
            chk("instr_valid", 32'(instr_valid), 32'(sb.size() != 0));
            if (instr_valid && first_valid < 0) first_valid = since;
            if (instr_valid && instr_ready && !redirect_valid && sb.size() > 0) begin
                e = sb.pop_front();
                chk("instr_pc", instr_pc, e.pc);
                chk("instr", instr, e.word);
                pop_log.push_back(instr_pc);
            end
            if (imem_rsp_valid) begin
                m = mq.pop_front();
                if (!m.stale && !redirect_valid) sb.push_back('{mem_word(m.addr), m.addr});
            end
            if (redirect_valid) begin
                sb.delete();
                foreach (mq[i]) mq[i].stale = 1'b1;
                mpc = {redirect_pc[31:2], 2'b00};
            end else if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{cyc + lat, imem_req_addr, 1'b0});
                acc_log.push_back(imem_req_addr);
                mpc = mpc + 32'd4;
            end
            since++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int l);
        rst = 1'b1; redirect_valid = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
        tick(); tick();
        rst = 1'b0; lat = l;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int guard;
        #1;
        // Streaming, latency 1
        do_reset(1);
        run(10);
        chk("t1_first_valid", 32'(first_valid), 32'd2);
        chk("t1_pop_n", 32'(pop_log.size() >= 3), 32'd1);
        if (pop_log.size() >= 3) begin
            chk("t1_pc0", pop_log[0], 32'h0);
            chk("t1_pc1", pop_log[1], 32'h4);
            chk("t1_pc2", pop_log[2], 32'h8);
        end

        // Decode stalled: credit stops at FIFO_DEPTH
        do_reset(1);
        instr_ready = 1'b0;
        run(8);
        chk("t2_accepts", 32'(acc_log.size()), 32'(DEPTH));
        chk("t2_req_stopped", 32'(s_req_valid), 32'd0);
        instr_ready = 1'b1;
        run(12);
        chk("t2_resumed", 32'(acc_log.size() > DEPTH), 32'd1);
        if (pop_log.size() >= 4) begin
            chk("t2_pc0", pop_log[0], 32'h0);
            chk("t2_pc3", pop_log[3], 32'hC);
        end else chk("t2_pop_n", 32'(pop_log.size()), 32'd4);

        // Redirect with two late responses outstanding
        do_reset(3);
        run(2);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        chk("t3_redir_noreq", 32'(s_req_valid), 32'd0);
        redirect_valid = 1'b0;
        tick();
        chk("t3_req_valid", 32'(s_req_valid), 32'd1);
        chk("t3_req_addr", s_req_addr, 32'h0000_0100);
        pop_log.delete();
        guard = 0;
        while (pop_log.size() == 0 && guard < 40) begin tick(); guard++; end
        chk("t3_first_pc", pop_log.size() > 0 ? pop_log[0] : 32'hDEAD_BEEF, 32'h0000_0100);

        // Redirect coinciding with a response and a pop while two entries are buffered
        do_reset(1);
        instr_ready = 1'b0;
        guard = 0;
        while (!(sb.size() == 2 && mq.size() > 0 && mq[0].due == cyc) && guard < 40) begin
            tick(); guard++;
        end
        chk("t4_setup", 32'(guard < 40), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0400; instr_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("t4_flushed", 32'(s_instr_valid), 32'd0);
        run(6);

        // PC wrap at top of address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        acc_log.delete();
        run(3);
        chk("t5_n", 32'(acc_log.size()), 32'd3);
        if (acc_log.size() >= 3) begin
            chk("t5_a0", acc_log[0], 32'hFFFF_FFF8);
            chk("t5_a1", acc_log[1], 32'hFFFF_FFFC);
            chk("t5_a2", acc_log[2], 32'h0000_0000);
        end
        run(6);

`ifdef FETCH_PERF_CNT_EN
        do_reset(4);
        guard = 0;
        while (!s_instr_valid && guard < 40) begin tick(); guard++; end
        chk("t6_stall_cnt", s_stall, 32'd5);
        run(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_stall_clear", s_stall, 32'd0);
`endif

        // Random backpressure and redirects, latency 2
        do_reset(2);
        for (int i = 0; i < 400; i++) begin
            imem_req_ready = $urandom_range(0, 3) != 0;
            instr_ready    = $urandom_range(0, 2) != 0;
            redirect_valid = $urandom_range(0, 19) == 0;
            redirect_pc    = $urandom & 32'h0000_FFFF;
            tick();
        end
        redirect_valid = 1'b0;
        chk("rand_progress", 32'(pop_log.size() > 50), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
